rvm_gpr_wb_arb: RTL and testbench
=================================

RVM_GPR_WB_ARB -- requirements
Module: rvm_gpr_wb_arb

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: GPR data width.
REQ-002 The block SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-003 The block SHALL have port clk, input, 1: core clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have ports ex_valid/ex_ready, input/output, 1 each: execute-unit writeback handshake (requester 0).
REQ-006 The block SHALL have ports ex_addr/ex_wdata, input, 5/XLEN: execute-unit destination register and data.
REQ-007 The block SHALL have ports ls_valid/ls_ready, input/output, 1 each: load/store-unit writeback handshake (requester 1).
REQ-008 The block SHALL have ports ls_addr/ls_wdata, input, 5/XLEN: load/store-unit destination register and data.
REQ-009 The block SHALL have ports rd_wen/rd_addr/rd_wdata, output, 1/5/XLEN: GPR write port, driven directly from registers.
REQ-010 The block SHALL have ports chk_rs1_addr/chk_rs2_addr, input, 5 each: source registers of the instruction being decoded.
REQ-011 The block SHALL have port hazard, output, 1: a chk address has a write in flight.
REQ-012 The block SHALL have port clk_req, output, 1: the block or the GPRs need a clock this cycle.

Function
REQ-013 A transfer SHALL occur on requester i when valid_i and ready_i are both high at a rising edge.
REQ-014 At most one ready SHALL be high per cycle; ready SHALL be combinational from the valids and the priority state.
REQ-015 With one requester valid, that requester SHALL get ready.
REQ-016 With both valid and RR_EN=1, the requester not granted most recently SHALL get ready; the last-grant pointer SHALL update only on a transfer.
REQ-017 With both valid and RR_EN=0, ex SHALL always win.
REQ-018 A transfer at edge N SHALL drive rd_wen=1, with the captured addr and data, for exactly the cycle after edge N; with no transfer, rd_wen SHALL be 0 on the next cycle.
REQ-019 Back-to-back transfers SHALL be accepted every cycle; throughput SHALL be one write per cycle.
REQ-020 A transfer with addr 0 SHALL complete its handshake, but rd_wen SHALL stay 0 in the following cycle.
REQ-021 rd_addr/rd_wdata SHALL hold their last values while rd_wen=0.
REQ-022 hazard SHALL be high when a nonzero chk_rs1_addr or chk_rs2_addr equals (a) rd_addr while rd_wen=1, or (b) ex_addr while ex_valid=1, or (c) ls_addr while ls_valid=1.
REQ-023 hazard SHALL never be high for a chk address of 0.
REQ-024 clk_req SHALL equal rd_wen OR ex_valid OR ls_valid.
REQ-025 A valid SHALL NOT be withdrawn and its addr/data SHALL NOT change before the transfer; the bench SHALL flag a violation as an assertion error.

Reset
REQ-026 With reset high at an edge, rd_wen SHALL be 0, rd_addr SHALL be 0, rd_wdata SHALL be 0, and the last-grant pointer SHALL be 1, so ex wins the first tie.
REQ-027 During reset, ex_ready and ls_ready SHALL be 0 and no transfer SHALL occur, even with valids high.
REQ-028 A write captured at the edge before reset asserts SHALL be dropped: the output register is cleared at the reset edge.

Verification
REQ-029 ex only: ex_valid=1, ex_addr=5, ex_wdata=0xDEADBEEF for 1 cycle -> ex_ready=1; next cycle rd_wen=1, rd_addr=5, rd_wdata=0xDEADBEEF; the cycle after, rd_wen=0.
REQ-030 Contention, RR_EN=1: both valid for 4 cycles (ex addr 1, ls addr 2) -> grants ex, ls, ex, ls; rd_addr sequence 1, 2, 1, 2 on consecutive cycles.
REQ-031 Contention, RR_EN=0: both valid for 3 cycles -> ex granted all 3 cycles; ls_ready=0 throughout.
REQ-032 x0 suppression: ls_valid=1, ls_addr=0, ls_wdata=0x1234 -> ls_ready=1, rd_wen=0 next cycle; hazard=0 for chk_rs1_addr=0.
REQ-033 Hazard: ex_valid=1, ex_addr=7, chk_rs2_addr=7 -> hazard=1 in the same cycle; next cycle, with ex_valid=0 and rd_wen=1/rd_addr=7, hazard=1; the cycle after, hazard=0.
REQ-034 Reset mid-stream: reset=1 at the edge where ex_valid=1 -> no transfer; rd_wen=0 the next cycle; after release, the first tie grants ex.

Source files
------------

// File: rtl/rvm_gpr_wb_arb_if.sv
// ---------------------------------------------------------------------------
// rvm_gpr_wb_arb_if
// Purpose : bundles the writeback arbiter's bus signals. The two writeback
//           requesters (execute and load/store), the GPR write port, the
//           decode-stage hazard check and the clock request all travel here.
// Modports:
//   master : requester/decode side (drives valids, addrs, data, chk addrs;
//            observes readies, GPR write port, hazard, clk_req)
//   slave  : the arbiter itself
// Signals :
//   ex_valid/ex_ready, ex_addr[4:0], ex_wdata[XLEN-1:0]  requester 0
//   ls_valid/ls_ready, ls_addr[4:0], ls_wdata[XLEN-1:0]  requester 1
//   rd_wen, rd_addr[4:0], rd_wdata[XLEN-1:0]             GPR write port
//   chk_rs1_addr[4:0], chk_rs2_addr[4:0], hazard         operand hazard check
//   clk_req                                              clock-gate request
// ---------------------------------------------------------------------------
interface rvm_gpr_wb_arb_if #(
  parameter int XLEN = 32
);

  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_addr;
  logic [XLEN-1:0] ex_wdata;

  logic            ls_valid;
  logic            ls_ready;
  logic [4:0]      ls_addr;
  logic [XLEN-1:0] ls_wdata;

  logic            rd_wen;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;

  logic [4:0]      chk_rs1_addr;
  logic [4:0]      chk_rs2_addr;
  logic            hazard;

  logic            clk_req;

  modport master (
    output ex_valid, ex_addr, ex_wdata,
    output ls_valid, ls_addr, ls_wdata,
    output chk_rs1_addr, chk_rs2_addr,
    input  ex_ready, ls_ready,
    input  rd_wen, rd_addr, rd_wdata,
    input  hazard, clk_req
  );

  modport slave (
    input  ex_valid, ex_addr, ex_wdata,
    input  ls_valid, ls_addr, ls_wdata,
    input  chk_rs1_addr, chk_rs2_addr,
    output ex_ready, ls_ready,
    output rd_wen, rd_addr, rd_wdata,
    output hazard, clk_req
  );

endinterface

// File: rtl/rvm_gpr_wb_arb.sv
// ---------------------------------------------------------------------------
// rvm_gpr_wb_arb
// Purpose : arbitrates the execute unit and the load/store unit for the
//           single GPR write port. One write per cycle, registered output,
//           writes to x0 are accepted but never reach the register file.
//           Also flags read-after-write hazards for the instruction in decode
//           and requests a clock whenever any write is pending or in flight.
// Parameters:
//   XLEN  : GPR data width
//   RR_EN : 1 = round-robin between requesters, 0 = execute unit always wins
// Ports   :
//   clk   : core clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   wb    : rvm_gpr_wb_arb_if.slave bundle (see interface header)
// ---------------------------------------------------------------------------
module rvm_gpr_wb_arb #(
  parameter int          XLEN  = 32,
  parameter int unsigned RR_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  rvm_gpr_wb_arb_if.slave    wb
);

  typedef enum logic {
    GRANT_EX = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  grant_e          lastGrant_q, lastGrant_d;
  logic            rdWen_q, rdWen_d;
  logic [4:0]      rdAddr_q, rdAddr_d;
  logic [XLEN-1:0] rdWdata_q, rdWdata_d;

  logic            exReady, lsReady;
  logic            exFire, lsFire;
  logic            rs1Hit, rs2Hit;

  // Grant selection. Readies are held low throughout reset so nothing can
  // transfer at a reset edge. On a tie the requester that did not win most
  // recently gets the port when round-robin is enabled.
  always_comb begin
    exReady = 1'b0;
    lsReady = 1'b0;
    if (!reset) begin
      if (wb.ex_valid && wb.ls_valid) begin
        if ((RR_EN != 0) && (lastGrant_q == GRANT_EX)) begin
          lsReady = 1'b1;
        end else begin
          exReady = 1'b1;
        end
      end else begin
        exReady = wb.ex_valid;
        lsReady = wb.ls_valid;
      end
    end
  end

  assign exFire = wb.ex_valid && exReady;
  assign lsFire = wb.ls_valid && lsReady;

  // Next-state for the output register and the last-grant pointer. The
  // pointer moves on every transfer, including x0 writes, but an x0 write
  // leaves the output register (and its held addr/data) untouched.
  always_comb begin
    rdWen_d     = 1'b0;
    rdAddr_d    = rdAddr_q;
    rdWdata_d   = rdWdata_q;
    lastGrant_d = lastGrant_q;
    if (exFire) begin
      lastGrant_d = GRANT_EX;
      if (wb.ex_addr != 5'd0) begin
        rdWen_d   = 1'b1;
        rdAddr_d  = wb.ex_addr;
        rdWdata_d = wb.ex_wdata;
      end
    end else if (lsFire) begin
      lastGrant_d = GRANT_LS;
      if (wb.ls_addr != 5'd0) begin
        rdWen_d   = 1'b1;
        rdAddr_d  = wb.ls_addr;
        rdWdata_d = wb.ls_wdata;
      end
    end
  end

  // State registers. Reset drops any write captured on the previous edge and
  // parks the pointer on ls so that ex wins the first tie afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdWen_q     <= 1'b0;
      rdAddr_q    <= 5'd0;
      rdWdata_q   <= '0;
      lastGrant_q <= GRANT_LS;
    end else begin
      rdWen_q     <= rdWen_d;
      rdAddr_q    <= rdAddr_d;
      rdWdata_q   <= rdWdata_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // A source operand is hazardous if any write to it is still pending at a
  // requester or is being written this cycle. x0 is never hazardous.
  always_comb begin
    rs1Hit = (wb.chk_rs1_addr != 5'd0) &&
             ((rdWen_q     && (wb.chk_rs1_addr == rdAddr_q))   ||
              (wb.ex_valid && (wb.chk_rs1_addr == wb.ex_addr)) ||
              (wb.ls_valid && (wb.chk_rs1_addr == wb.ls_addr)));
    rs2Hit = (wb.chk_rs2_addr != 5'd0) &&
             ((rdWen_q     && (wb.chk_rs2_addr == rdAddr_q))   ||
              (wb.ex_valid && (wb.chk_rs2_addr == wb.ex_addr)) ||
              (wb.ls_valid && (wb.chk_rs2_addr == wb.ls_addr)));
  end

  assign wb.ex_ready = exReady;
  assign wb.ls_ready = lsReady;
  assign wb.rd_wen   = rdWen_q;
  assign wb.rd_addr  = rdAddr_q;
  assign wb.rd_wdata = rdWdata_q;
  assign wb.hazard   = rs1Hit || rs2Hit;
  assign wb.clk_req  = rdWen_q || wb.ex_valid || wb.ls_valid;

endmodule

// File: tb/tb_rvm_gpr_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_rvm_gpr_wb_arb
// Purpose : directed testbench for rvm_gpr_wb_arb. Two instances share clock
//           and reset: dutRr (round-robin) and dutFp (fixed priority).
//           Inputs are driven 1 time unit after the rising edge and outputs
//           are compared 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_rvm_gpr_wb_arb;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  rvm_gpr_wb_arb_if #(.XLEN(32)) rrIf ();
  rvm_gpr_wb_arb_if #(.XLEN(32)) fpIf ();

  rvm_gpr_wb_arb #(.XLEN(32), .RR_EN(1)) dutRr (
    .clk   (clk),
    .reset (reset),
    .wb    (rrIf)
  );

  rvm_gpr_wb_arb #(.XLEN(32), .RR_EN(0)) dutFp (
    .clk   (clk),
    .reset (reset),
    .wb    (fpIf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester protocol watch: once a valid has been left waiting at an edge
  // outside reset, it must still be valid with unchanged addr/data at the
  // following edge.
  logic        rrExPend, rrLsPend, fpExPend, fpLsPend;
  logic [4:0]  rrExA, rrLsA, fpExA, fpLsA;
  logic [31:0] rrExD, rrLsD, fpExD, fpLsD;

  initial begin
    rrExPend = 1'b0; rrLsPend = 1'b0; fpExPend = 1'b0; fpLsPend = 1'b0;
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (rrExPend) begin
        checks++;
        assert (rrIf.ex_valid === 1'b1 && rrIf.ex_addr === rrExA && rrIf.ex_wdata === rrExD)
          else begin errors++; $error("[TB] FAIL proto_rr_ex: ex request withdrawn or changed before transfer"); end
      end
      if (rrLsPend) begin
        checks++;
        assert (rrIf.ls_valid === 1'b1 && rrIf.ls_addr === rrLsA && rrIf.ls_wdata === rrLsD)
          else begin errors++; $error("[TB] FAIL proto_rr_ls: ls request withdrawn or changed before transfer"); end
      end
      if (fpExPend) begin
        checks++;
        assert (fpIf.ex_valid === 1'b1 && fpIf.ex_addr === fpExA && fpIf.ex_wdata === fpExD)
          else begin errors++; $error("[TB] FAIL proto_fp_ex: ex request withdrawn or changed before transfer"); end
      end
      if (fpLsPend) begin
        checks++;
        assert (fpIf.ls_valid === 1'b1 && fpIf.ls_addr === fpLsA && fpIf.ls_wdata === fpLsD)
          else begin errors++; $error("[TB] FAIL proto_fp_ls: ls request withdrawn or changed before transfer"); end
      end
    end
    rrExPend <= !reset && rrIf.ex_valid && !rrIf.ex_ready;
    rrLsPend <= !reset && rrIf.ls_valid && !rrIf.ls_ready;
    fpExPend <= !reset && fpIf.ex_valid && !fpIf.ex_ready;
    fpLsPend <= !reset && fpIf.ls_valid && !fpIf.ls_ready;
    rrExA <= rrIf.ex_addr; rrExD <= rrIf.ex_wdata;
    rrLsA <= rrIf.ls_addr; rrLsD <= rrIf.ls_wdata;
    fpExA <= fpIf.ex_addr; fpExD <= fpIf.ex_wdata;
    fpLsA <= fpIf.ls_addr; fpLsD <= fpIf.ls_wdata;
  end

  // Drive one instance's inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input bit toFp,
                               input logic exV, input logic [4:0] exA, input logic [31:0] exD,
                               input logic lsV, input logic [4:0] lsA, input logic [31:0] lsD,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    if (toFp) begin
      fpIf.ex_valid = exV; fpIf.ex_addr = exA; fpIf.ex_wdata = exD;
      fpIf.ls_valid = lsV; fpIf.ls_addr = lsA; fpIf.ls_wdata = lsD;
      fpIf.chk_rs1_addr = rs1; fpIf.chk_rs2_addr = rs2;
    end else begin
      rrIf.ex_valid = exV; rrIf.ex_addr = exA; rrIf.ex_wdata = exD;
      rrIf.ls_valid = lsV; rrIf.ls_addr = lsA; rrIf.ls_wdata = lsD;
      rrIf.chk_rs1_addr = rs1; rrIf.chk_rs2_addr = rs2;
    end
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: reset, single writes, x0, round-robin contention,
  // hazards, reset mid-stream, then fixed-priority contention.
  initial begin
    bit grantEx [4];
    grantEx = '{1'b1, 1'b0, 1'b1, 1'b0};

    $display("[TB] start");
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) waitCycle();
    checkOutput("rst_rd_wen",   rrIf.rd_wen,   0);
    checkOutput("rst_rd_addr",  rrIf.rd_addr,  0);
    checkOutput("rst_rd_wdata", rrIf.rd_wdata, 0);
    checkOutput("rst_fp_wen",   fpIf.rd_wen,   0);

    // Single ex write to x5.
    reset = 1'b0;
    applyStimulus(1'b0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checkOutput("ex_only_ready",    rrIf.ex_ready, 1);
    checkOutput("ex_only_ls_ready", rrIf.ls_ready, 0);
    checkOutput("ex_only_clkreq",   rrIf.clk_req,  1);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ex_only_wen",    rrIf.rd_wen,   1);
    checkOutput("ex_only_addr",   rrIf.rd_addr,  5);
    checkOutput("ex_only_wdata",  rrIf.rd_wdata, 32'hDEADBEEF);
    checkOutput("ex_only_clkreq2", rrIf.clk_req, 1);
    waitCycle();
    checkOutput("ex_only_wen_off", rrIf.rd_wen,  0);
    checkOutput("idle_clkreq",     rrIf.clk_req, 0);

    // ls write to x0: handshake completes, nothing written, outputs held.
    applyStimulus(1'b0, 0, 0, 0, 1, 0, 32'h1234, 0, 0);
    checkOutput("x0_ls_ready", rrIf.ls_ready, 1);
    checkOutput("x0_hazard",   rrIf.hazard,   0);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_wen",        rrIf.rd_wen,   0);
    checkOutput("x0_hold_addr",  rrIf.rd_addr,  5);
    checkOutput("x0_hold_wdata", rrIf.rd_wdata, 32'hDEADBEEF);

    // Round-robin contention, ls won last so ex goes first.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      checkOutput($sformatf("rr_ex_ready_%0d", k), rrIf.ex_ready, grantEx[k]);
      checkOutput($sformatf("rr_ls_ready_%0d", k), rrIf.ls_ready, !grantEx[k]);
      if (k > 0) begin
        checkOutput($sformatf("rr_wen_%0d", k),  rrIf.rd_wen,  1);
        checkOutput($sformatf("rr_addr_%0d", k), rrIf.rd_addr, grantEx[k-1] ? 32'd1 : 32'd2);
      end
      waitCycle();
    end
    // ex was left waiting by the last grant; let it finish alone.
    applyStimulus(1'b0, 1, 1, 32'h11, 0, 0, 0, 0, 0);
    checkOutput("rr_tail_ex_ready", rrIf.ex_ready, 1);
    checkOutput("rr_tail_addr",     rrIf.rd_addr,  2);
    checkOutput("rr_tail_wdata",    rrIf.rd_wdata, 32'h22);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_last_wen",   rrIf.rd_wen,   1);
    checkOutput("rr_last_addr",  rrIf.rd_addr,  1);
    checkOutput("rr_last_wdata", rrIf.rd_wdata, 32'h11);
    waitCycle();

    // Hazard through a pending ex write, then through the write port.
    applyStimulus(1'b0, 1, 7, 32'h77, 0, 0, 0, 0, 7);
    checkOutput("hz_ex_pending", rrIf.hazard, 1);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 7);
    checkOutput("hz_wen",       rrIf.rd_wen,  1);
    checkOutput("hz_addr",      rrIf.rd_addr, 7);
    checkOutput("hz_writeback", rrIf.hazard,  1);
    waitCycle();
    checkOutput("hz_cleared", rrIf.hazard, 0);

    // Hazard through a pending ls write on rs1; then x0 checks never hit.
    applyStimulus(1'b0, 0, 0, 0, 1, 9, 32'h99, 9, 0);
    checkOutput("hz_ls_pending", rrIf.hazard, 1);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("hz_ls_addr",   rrIf.rd_addr, 9);
    checkOutput("hz_zero_addr", rrIf.hazard,  0);
    waitCycle();

    // Reset mid-stream: a write captured just before reset is dropped, the
    // request seen during reset does not transfer, ex wins the first tie.
    applyStimulus(1'b0, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    waitCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 1, 3, 32'h33, 0, 0, 0, 0, 0);
    checkOutput("mid_pre_wen",  rrIf.rd_wen,   1);
    checkOutput("mid_pre_addr", rrIf.rd_addr,  4);
    checkOutput("mid_ex_ready", rrIf.ex_ready, 0);
    waitCycle();
    checkOutput("mid_wen",         rrIf.rd_wen,   0);
    checkOutput("mid_addr",        rrIf.rd_addr,  0);
    checkOutput("mid_wdata",       rrIf.rd_wdata, 0);
    checkOutput("mid_ex_ready_rst", rrIf.ex_ready, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1, 3, 32'h33, 1, 6, 32'h66, 0, 0);
    checkOutput("post_rst_ex_ready", rrIf.ex_ready, 1);
    checkOutput("post_rst_ls_ready", rrIf.ls_ready, 0);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 1, 6, 32'h66, 0, 0);
    checkOutput("post_rst_ls_go", rrIf.ls_ready, 1);
    checkOutput("post_rst_addr3", rrIf.rd_addr,  3);
    waitCycle();
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("post_rst_addr6",  rrIf.rd_addr,  6);
    checkOutput("post_rst_wdata6", rrIf.rd_wdata, 32'h66);
    waitCycle();

    // Fixed priority: ex wins every tie, ls only goes once ex drops.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      checkOutput($sformatf("fp_ex_ready_%0d", k), fpIf.ex_ready, 1);
      checkOutput($sformatf("fp_ls_ready_%0d", k), fpIf.ls_ready, 0);
      if (k > 0) begin
        checkOutput($sformatf("fp_addr_%0d", k), fpIf.rd_addr, 1);
      end
      waitCycle();
    end
    applyStimulus(1'b1, 0, 0, 0, 1, 2, 32'h22, 0, 0);
    checkOutput("fp_ls_go",   fpIf.ls_ready, 1);
    checkOutput("fp_addr_ex", fpIf.rd_addr,  1);
    waitCycle();
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fp_wen_ls",  fpIf.rd_wen,  1);
    checkOutput("fp_addr_ls", fpIf.rd_addr, 2);
    waitCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
